fetch_pc: RTL
=============

# fetch_pc

Fetch-stage next-PC generator with an internal 32-entry branch target buffer (BTB). It holds the architectural fetch PC that drives instruction memory and the branch direction predictor. It combines the predictor's taken/not-taken hint with a BTB target to steer fetch, and honours the MIPS branch delay slot. Execute-stage mispredict redirects and BTB training arrive from downstream.

## Interface
- RESET_PC, 32'hBFC0_0000, fetch address after reset
- BTB_IDX_W, 5, BTB index width (2^BTB_IDX_W entries, index = PC[BTB_IDX_W+1:2])

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- stall  in  1  hold PC and FSM state this cycle
- Is_Branch  in  1  fetched instruction at PC is a conditional branch (from predictor)
- Branch_likely  in  1  predictor direction for instruction at PC
- redirect  in  1  EX mispredict/flush; highest priority
- redirect_pc  in  32  correct fetch address when redirect=1
- btb_we  in  1  train BTB this edge
- btb_pc  in  32  branch PC being trained
- btb_target  in  32  resolved taken target
- PC  out  32  current fetch address (registered)
- pred_taken  out  1  fetch predicts the branch at PC taken (combinational)
- pred_target  out  32  BTB target for PC; valid when pred_taken=1

## Operation
- BTB: direct-mapped. Entry = {valid, tag = PC[31:BTB_IDX_W+2], target[31:0]}. hit = valid && tag match on PC.
- pred_taken = (state==SEQ) && Is_Branch && Branch_likely && hit. A predictor "taken" with a BTB miss is treated as not taken.
- FSM states:
  - SEQ: normal sequential fetch.
  - SLOT: the delay slot is being fetched while the taken target is held in pend_target.
- Next-state and PC priority, evaluated on each edge:
  1. redirect=1: PC<=redirect_pc, state<=SEQ, pending target discarded. Ignores stall.
  2. stall=1: PC, state and pend_target hold.
  3. SEQ with pred_taken=1: PC<=PC+4, pend_target<=pred_target, state<=SLOT.
  4. SEQ otherwise: PC<=PC+4.
  5. SLOT: PC<=pend_target, state<=SEQ. Prediction inputs are ignored in SLOT, since a branch in a delay slot is architecturally illegal.
- PC+4 wraps modulo 2^32. PC[1:0] is never generated nonzero by this block; redirect_pc is passed as-is.
- BTB write when btb_we=1: the entry at btb_pc's index gets valid=1, tag and target, replacing the existing contents. btb_we is independent of stall and redirect.

## Timing
- Reset values:
  - PC=RESET_PC
  - state=SEQ
  - pend_target=0
  - all BTB valid=0
  - pred_taken=0
  - pred_target=0
- BTB lookup is combinational on PC; the BTB write takes effect after the edge.
- A same-cycle write and lookup to the same index returns the old contents, with no bypass.
- Predicted-taken branch at address A: cycle n PC=A, n+1 PC=A+4 (delay slot), n+2 PC=target.
- Redirect latency: PC=redirect_pc on the edge after redirect is sampled high.
- Reset asserted mid-SLOT: the pending target is lost; PC returns to RESET_PC asynchronously.

## Structure
- Shared package holds:
  - RESET_PC default
  - state encoding (SEQ=1'b0, SLOT=1'b1)
  - BTB tag width derivation from BTB_IDX_W
- Sub-module btb: the storage array, combinational lookup port and synchronous write port.
- fetch_pc keeps the FSM, the PC register, pend_target and the priority mux.

## Test plan
- Reset and sequential fetch: assert reset, release, no stimulus -> PC = BFC00000, BFC00004, BFC00008; pred_taken=0.
- Trained taken branch:
  - Stimulus: btb_we with btb_pc=BFC00010, btb_target=BFC00100; later PC reaches BFC00010 with Is_Branch=1, Branch_likely=1.
  - Response: pred_taken=1, pred_target=BFC00100; next PCs BFC00014 then BFC00100.
- Predictor taken with BTB miss: Is_Branch=1, Branch_likely=1 at untrained PC BFC00020 -> pred_taken=0, next PC BFC00024, state stays SEQ.
- Redirect during SLOT: in SLOT with pend_target=BFC00100, redirect=1 and redirect_pc=BFC00200 -> next PC BFC00200; next cycle PC=BFC00204 (pending target discarded).
- Stall in SLOT, then redirect under stall:
  - stall=1 for 3 cycles in SLOT -> PC and state frozen; after release PC=pend_target.
  - Separately, redirect=1 with stall=1 -> PC=redirect_pc.
- Alias and write/read collision:
  - Train BFC00010; lookup 80000010 (same index, different tag) -> miss.
  - btb_we to the current PC's index in the same cycle as the lookup -> old result; the new entry is visible on the next cycle.

Source files
------------

// File: rtl/fetch_pc_pkg.sv
// Shared definitions for the fetch next-PC generator: reset address, FSM
// encoding and BTB geometry helpers.
package fetch_pc_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'hBFC0_0000;
  localparam int unsigned BTB_IDX_W_DEFAULT = 5;

  typedef enum logic {
    SEQ  = 1'b0,
    SLOT = 1'b1
  } fetch_state_e;

  // Tag covers every PC bit above the index; bits [1:0] are the byte offset.
  function automatic int unsigned btb_tag_w(input int unsigned idx_w);
    return 32 - idx_w - 2;
  endfunction

endpackage

// File: rtl/fetch_pc_if.sv
// Fetch-stage bus: predictor hints, EX redirect, BTB training and the
// resulting fetch address / prediction.
interface fetch_pc_if;

  logic        stall;
  logic        Is_Branch;
  logic        Branch_likely;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        btb_we;
  logic [31:0] btb_pc;
  logic [31:0] btb_target;
  logic [31:0] PC;
  logic        pred_taken;
  logic [31:0] pred_target;

  modport master (
    output stall, Is_Branch, Branch_likely, redirect, redirect_pc,
           btb_we, btb_pc, btb_target,
    input  PC, pred_taken, pred_target
  );

  modport slave (
    input  stall, Is_Branch, Branch_likely, redirect, redirect_pc,
           btb_we, btb_pc, btb_target,
    output PC, pred_taken, pred_target
  );

endinterface

// File: rtl/fetch_pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup, synchronous
// write, valid bits cleared by asynchronous reset.
module fetch_pc_btb
  import fetch_pc_pkg::*;
#(
  parameter int unsigned IDX_W = BTB_IDX_W_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lookup_pc,
  output logic        hit,
  output logic [31:0] target,
  input  logic        we,
  input  logic [31:0] wr_pc,
  input  logic [31:0] wr_target
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned TAG_W   = btb_tag_w(IDX_W);

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [31:0]        targets [ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [TAG_W-1:0] wr_tag;
  logic             unused_byte_offset;

  assign rd_idx = lookup_pc[IDX_W+1:2];
  assign rd_tag = lookup_pc[31:IDX_W+2];
  assign wr_idx = wr_pc[IDX_W+1:2];
  assign wr_tag = wr_pc[31:IDX_W+2];
  assign unused_byte_offset = ^{lookup_pc[1:0], wr_pc[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: a cleared valid bit masks stale contents.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_idx]    <= wr_tag;
      targets[wr_idx] <= wr_target;
    end
  end

  // Reads see pre-edge contents; a same-cycle write is not bypassed.
  always_comb begin
    hit    = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    target = hit ? targets[rd_idx] : '0;
  end

endmodule

// File: rtl/fetch_pc.sv
// Fetch PC register and SEQ/SLOT delay-slot FSM; steers fetch using the
// predictor direction and the internal BTB.
module fetch_pc
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BTB_IDX_W = BTB_IDX_W_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  fetch_pc_if.slave  bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_q, pend_d;
  logic         btb_hit;
  logic [31:0]  btb_target;
  logic         pred_taken;

  fetch_pc_btb #(
    .IDX_W (BTB_IDX_W)
  ) u_btb (
    .clk       (clk),
    .reset     (reset),
    .lookup_pc (pc_q),
    .hit       (btb_hit),
    .target    (btb_target),
    .we        (bus.btb_we),
    .wr_pc     (bus.btb_pc),
    .wr_target (bus.btb_target)
  );

  // A predicted-taken hint without a BTB target cannot steer fetch.
  assign pred_taken = (state_q == SEQ) && bus.Is_Branch && bus.Branch_likely && btb_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SEQ;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    if (bus.redirect) begin
      pc_d    = bus.redirect_pc;
      state_d = SEQ;
      pend_d  = '0;
    end else if (!bus.stall) begin
      unique case (state_q)
        SEQ: begin
          pc_d = pc_q + 32'd4;
          if (pred_taken) begin
            pend_d  = btb_target;
            state_d = SLOT;
          end
        end
        SLOT: begin
          pc_d    = pend_q;
          state_d = SEQ;
        end
      endcase
    end
  end

  assign bus.PC          = pc_q;
  assign bus.pred_taken  = pred_taken;
  assign bus.pred_target = btb_target;

endmodule
